// File: rtl/sirv_plic_claim_agent.sv
// Claim/complete agent for the hart-0 machine-mode PLIC context: reads the claim register,
// hands the ID to a consumer, and writes the same ID back once the consumer signals completion.
module sirv_plic_claim_agent #(
    parameter logic [31:0] PLIC_CLAIM_ADDR = 32'h0C20_0004,
    parameter int unsigned ID_W            = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            plic_irq_i,
    output logic            o_icb_cmd_valid,
    input  logic            o_icb_cmd_ready,
    output logic [31:0]     o_icb_cmd_addr,
    output logic            o_icb_cmd_read,
    output logic [31:0]     o_icb_cmd_wdata,
    input  logic            o_icb_rsp_valid,
    output logic            o_icb_rsp_ready,
    input  logic [31:0]     o_icb_rsp_rdata,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [ID_W-1:0] id,
    input  logic            cpl_valid,
    output logic            cpl_ready,
    output logic            busy,
    output logic [7:0]      spur_cnt,
    output logic [2:0]      dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // a raised valid (and its payload) holds until that edge, and ready never depends on valid.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLM_CMD  = 3'd1,
        CLM_RSP  = 3'd2,
        PRESENT  = 3'd3,
        WAIT_CPL = 3'd4,
        CPL_CMD  = 3'd5,
        CPL_RSP  = 3'd6
    } state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [7:0]      spur_q, spur_d;
    logic            cmd_valid_q, cmd_read_q, rsp_ready_q, id_valid_q, cpl_ready_q, busy_q;
    logic [31:0]     cmd_addr_q, cmd_wdata_q;
    logic            unused_rdata_hi;

    // Only the low ID_W bits of the claim register carry the interrupt ID.
    assign unused_rdata_hi = ^o_icb_rsp_rdata[31:ID_W];

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        spur_d  = spur_q;
        case (state_q)
            IDLE:     if (en && plic_irq_i) state_d = CLM_CMD;
            CLM_CMD:  if (cmd_valid_q && o_icb_cmd_ready) state_d = CLM_RSP;
            CLM_RSP: begin
                if (o_icb_rsp_valid) begin
                    id_d = o_icb_rsp_rdata[ID_W-1:0];
                    if (o_icb_rsp_rdata[ID_W-1:0] != '0) begin
                        state_d = PRESENT;
                    end else begin
                        // ID 0 means nothing was pending by the time the claim landed.
                        state_d = IDLE;
                        if (spur_q != 8'hFF) spur_d = spur_q + 8'd1;
                    end
                end
            end
            PRESENT:  if (id_valid_q && id_ready) state_d = WAIT_CPL;
            WAIT_CPL: if (cpl_valid) state_d = CPL_CMD;
            CPL_CMD:  if (cmd_valid_q && o_icb_cmd_ready) state_d = CPL_RSP;
            CPL_RSP:  if (o_icb_rsp_valid) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q after each edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            id_q        <= '0;
            spur_q      <= '0;
            cmd_valid_q <= 1'b0;
            cmd_read_q  <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rsp_ready_q <= 1'b0;
            id_valid_q  <= 1'b0;
            cpl_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            spur_q      <= spur_d;
            cmd_valid_q <= (state_d == CLM_CMD) || (state_d == CPL_CMD);
            cmd_read_q  <= (state_d == CLM_CMD);
            cmd_addr_q  <= ((state_d == CLM_CMD) || (state_d == CPL_CMD)) ? PLIC_CLAIM_ADDR : '0;
            cmd_wdata_q <= (state_d == CPL_CMD) ? {{(32-ID_W){1'b0}}, id_d} : '0;
            rsp_ready_q <= (state_d == CLM_RSP) || (state_d == CPL_RSP);
            id_valid_q  <= (state_d == PRESENT);
            cpl_ready_q <= (state_d == WAIT_CPL);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign o_icb_cmd_valid = cmd_valid_q;
    assign o_icb_cmd_read  = cmd_read_q;
    assign o_icb_cmd_addr  = cmd_addr_q;
    assign o_icb_cmd_wdata = cmd_wdata_q;
    assign o_icb_rsp_ready = rsp_ready_q;
    assign id_valid        = id_valid_q;
    assign id              = id_q;
    assign cpl_ready       = cpl_ready_q;
    assign busy            = busy_q;
    assign spur_cnt        = spur_q;
    assign dbg_state_o     = state_q;

endmodule

// File: doc/sirv_plic_claim_agent.md
SIRV_PLIC_CLAIM_AGENT -- requirements
Module: sirv_plic_claim_agent

Interface
REQ-001 Parameter PLIC_CLAIM_ADDR, default 32'h0C20_0004, SHALL be the ICB address of the hart-0 machine-mode claim/complete register.
REQ-002 Parameter ID_W, default 5, SHALL be the width of the interrupt ID; 18 sources need 5 bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 en  input  1  SHALL be the agent enable; when 0, no new claim starts.
REQ-006 plic_irq_i  input  1  SHALL be the level interrupt from the PLIC hart-0 output.
REQ-007 o_icb_cmd_valid/o_icb_cmd_ready  output/input  1/1  SHALL be the ICB initiator command handshake.
REQ-008 o_icb_cmd_addr  output  32  SHALL be the command address; o_icb_cmd_read  output  1  SHALL be 1 for read, 0 for write; o_icb_cmd_wdata  output  32  SHALL be write data.
REQ-009 o_icb_rsp_valid/o_icb_rsp_ready  input/output  1/1  SHALL be the response handshake; o_icb_rsp_rdata  input  32  SHALL be read data.
REQ-010 id_valid/id_ready  output/input  1/1, id  output  ID_W  SHALL hand the claimed ID to the consumer.
REQ-011 cpl_valid/cpl_ready  input/output  1/1  SHALL signal the consumer has finished servicing the presented ID.
REQ-012 busy  output  1  SHALL be 1 whenever state is not IDLE; spur_cnt  output  8  SHALL count spurious claims.

Function
REQ-013 The FSM SHALL have exactly these states: IDLE, CLM_CMD, CLM_RSP, PRESENT, WAIT_CPL, CPL_CMD, CPL_RSP.
REQ-014 IDLE->CLM_CMD when en=1 and plic_irq_i=1; otherwise the FSM stays in IDLE.
REQ-015 In CLM_CMD, o_icb_cmd_valid=1, addr=PLIC_CLAIM_ADDR, read=1, wdata=0; the FSM advances to CLM_RSP on valid&ready.
REQ-016 In CLM_RSP, o_icb_rsp_ready=1; on rsp_valid the agent captures rdata[ID_W-1:0] into id_q.
REQ-017 On that capture, the FSM goes to PRESENT if the captured ID is nonzero; if it is zero, the FSM returns to IDLE and spur_cnt increments, saturating at 8'hFF.
REQ-018 In PRESENT, id_valid=1 and id=id_q; the FSM goes to WAIT_CPL on id_valid&id_ready.
REQ-019 In WAIT_CPL, cpl_ready=1; the FSM goes to CPL_CMD on cpl_valid.
REQ-020 In CPL_CMD, o_icb_cmd_valid=1, addr=PLIC_CLAIM_ADDR, read=0, wdata=zero-extended id_q; the FSM goes to CPL_RSP on valid&ready.
REQ-021 In CPL_RSP, o_icb_rsp_ready=1; on rsp_valid the FSM goes to IDLE and the rdata is ignored.
REQ-022 All outputs SHALL be decoded from registered state only; no combinational path from any input to any output.
REQ-023 Once asserted, cmd_valid and id_valid SHALL hold, with addr/read/wdata/id stable, until their handshake completes.
REQ-024 o_icb_rsp_ready and cpl_ready SHALL be 0 in all states other than those named above.
REQ-025 At most one ICB transaction SHALL be outstanding; cmd_valid is never asserted in an RSP state.
REQ-026 Minimum latency: irq seen in IDLE at cycle N gives cmd_valid at N+1; with zero-wait ICB and consumer, the next claim can start one cycle after the completion response.
REQ-027 Deasserting en SHALL NOT abort a claim in flight; the sequence completes to IDLE.
REQ-028 A drop of plic_irq_i after CLM_CMD is entered SHALL NOT abort the sequence; the PLIC then returns ID 0, which is handled per REQ-017.
REQ-029 cpl_valid outside WAIT_CPL and rsp_valid outside RSP states SHALL be ignored.
REQ-030 id_q SHALL be written only in CLM_RSP on rsp_valid.

Reset
REQ-031 While rst=1: state=IDLE, id_q=0, spur_cnt=0, and all valid/ready outputs, busy, addr, wdata and read are 0.
REQ-032 Reset asserted mid-sequence SHALL abandon the sequence and return the FSM to IDLE in the next cycle; the ICB target is reset together with the agent.

Verification
REQ-033 irq=1, en=1, ready always 1, claim rdata=7, id_ready=1, cpl_valid pulse -> read at 0x0C200004, id=7 presented, write wdata=7, busy back to 0.
REQ-034 Claim rdata=0 -> no id_valid, return to IDLE, spur_cnt increments 0->1; a forced count of 255 stays at 255.
REQ-035 cmd_ready held 0 for 5 cycles, id_ready held 0 for 3 cycles -> cmd_valid/addr and id_valid/id stay stable throughout, with exactly one transaction each.
REQ-036 en=0 with irq=1 -> no cmd_valid; en dropped during CLM_RSP -> the sequence still completes.
REQ-037 rst pulsed in WAIT_CPL -> all outputs 0 next cycle; with irq=1 and en=1 after release, a fresh claim starts.
